// File: rtl/grid_scan_counter.sv
// Raster scan counter over a SIZE_X x SIZE_Y grid with stall, single-shot or continuous mode.
// Optional synchronous abort input enabled by defining GRID_SCAN_ABORT_EN.
module grid_scan_counter #(
  parameter int SIZE_X     = 40,
  parameter int SIZE_Y     = 20,
  parameter int CONTINUOUS = 0,
  localparam int X_W = (SIZE_X > 1) ? $clog2(SIZE_X) : 1,
  localparam int Y_W = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           start,
  input  logic           hold,
`ifdef GRID_SCAN_ABORT_EN
  input  logic           abort,
`endif
  output logic [X_W-1:0] index_x,
  output logic [Y_W-1:0] index_y,
  output logic           valid,
  output logic           last,
  output logic           next_round,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [X_W-1:0] X_MAX = X_W'(SIZE_X - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SIZE_Y - 1);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  state_t         state_r;
  state_t         state_s;
  logic [X_W-1:0] index_x_r;
  logic [X_W-1:0] index_x_s;
  logic [Y_W-1:0] index_y_r;
  logic [Y_W-1:0] index_y_s;
  logic           valid_s;
  logic           at_x_end_s;
  logic           at_y_end_s;
  logic           abort_s;

`ifdef GRID_SCAN_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // State and index registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r   <= ST_IDLE;
      index_x_r <= '0;
      index_y_r <= '0;
    end else begin
      state_r   <= state_s;
      index_x_r <= index_x_s;
      index_y_r <= index_y_s;
    end
  end

  // Cell-consumed qualifiers derived from the registered position
  always_comb begin
    valid_s    = (state_r == ST_SCAN) && !hold;
    at_x_end_s = (index_x_r == X_MAX);
    at_y_end_s = (index_y_r == Y_MAX);
  end

  // Next-state and index advance; row wraps in the same cycle as the column
  always_comb begin
    state_s   = state_r;
    index_x_s = index_x_r;
    index_y_s = index_y_r;
    case (state_r)
      ST_IDLE: begin
        index_x_s = '0;
        index_y_s = '0;
        if ((CONTINUOUS != 0) || start) begin
          state_s = ST_SCAN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (valid_s) begin
          if (at_x_end_s) begin
            index_x_s = '0;
            if (at_y_end_s) begin
              index_y_s = '0;
              state_s   = ST_DONE;
            end else begin
              index_y_s = index_y_r + Y_ONE;
            end
          end else begin
            index_x_s = index_x_r + X_ONE;
          end
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_DONE: begin
        index_x_s = '0;
        index_y_s = '0;
        if (CONTINUOUS != 0) begin
          state_s = ST_SCAN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        index_x_s = '0;
        index_y_s = '0;
      end
    endcase
    // Abort outranks every functional input; only Reset is stronger
    if (abort_s) begin
      state_s   = ST_IDLE;
      index_x_s = '0;
      index_y_s = '0;
    end else begin
      state_s = state_s;
    end
  end

  // Output decode
  always_comb begin
    index_x    = index_x_r;
    index_y    = index_y_r;
    valid      = valid_s;
    last       = valid_s && at_x_end_s && at_y_end_s;
    next_round = (state_r == ST_DONE);
    busy       = (state_r != ST_IDLE);
  end

endmodule

// File: tb/tb_grid_scan_counter.sv
// Directed self-checking bench for grid_scan_counter (4x3 single-shot, 4x3 continuous, 1x1, 1x2).
// Abort scenario is compiled only when GRID_SCAN_ABORT_EN is defined.
module tb_grid_scan_counter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, start, hold;
  logic [1:0] index_x, index_y;
  logic       valid, last, next_round, busy;

  logic       Reset_c;
  logic [1:0] index_x_c, index_y_c;
  logic       valid_c, last_c, next_round_c, busy_c;

  logic       s_start;
  logic       x11, y11, v11, l11, n11, b11;
  logic       x12, y12, v12, l12, n12, b12;

`ifdef GRID_SCAN_ABORT_EN
  logic abort;
`endif

  int checks   = 0;
  int failures = 0;

  grid_scan_counter #(.SIZE_X(4), .SIZE_Y(3), .CONTINUOUS(0)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .hold(hold),
`ifdef GRID_SCAN_ABORT_EN
    .abort(abort),
`endif
    .index_x(index_x), .index_y(index_y), .valid(valid), .last(last),
    .next_round(next_round), .busy(busy)
  );

  grid_scan_counter #(.SIZE_X(4), .SIZE_Y(3), .CONTINUOUS(1)) dut_c (
    .Clk(Clk), .Reset(Reset_c), .start(1'b0), .hold(1'b0),
`ifdef GRID_SCAN_ABORT_EN
    .abort(1'b0),
`endif
    .index_x(index_x_c), .index_y(index_y_c), .valid(valid_c), .last(last_c),
    .next_round(next_round_c), .busy(busy_c)
  );

  grid_scan_counter #(.SIZE_X(1), .SIZE_Y(1), .CONTINUOUS(0)) dut_11 (
    .Clk(Clk), .Reset(Reset), .start(s_start), .hold(1'b0),
`ifdef GRID_SCAN_ABORT_EN
    .abort(1'b0),
`endif
    .index_x(x11), .index_y(y11), .valid(v11), .last(l11),
    .next_round(n11), .busy(b11)
  );

  grid_scan_counter #(.SIZE_X(1), .SIZE_Y(2), .CONTINUOUS(0)) dut_12 (
    .Clk(Clk), .Reset(Reset), .start(s_start), .hold(1'b0),
`ifdef GRID_SCAN_ABORT_EN
    .abort(1'b0),
`endif
    .index_x(x12), .index_y(y12), .valid(v12), .last(l12),
    .next_round(n12), .busy(b12)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    start = 1'b1;
    hold  = 1'b0;
    tick();
    tick();
    start = 1'b0;
    #1;
    checks++;
    if ({valid, last, next_round, busy, index_x, index_y} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b",
               {valid, last, next_round, busy, index_x, index_y}, 8'h00);
    end
    Reset = 1'b1;
    tick();
    checks++;
    if ({valid, next_round, busy} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 000", {valid, next_round, busy});
    end
  endtask

  // Runs one full 4x3 scan, optionally with a hold burst or a start re-pulse
  task automatic run_scan(input string tag, input int hold_at, input int hold_len,
                          input int restart_at);
    int  cnt;
    int  held;
    int  vseen;
    int  nrseen;
    bit  done;
    cnt = 0; held = 0; vseen = 0; nrseen = 0; done = 1'b0;
    start = 1'b1;
    #1;
    checks++;
    if ({valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL %s_idle: got %b expected 00", tag, {valid, busy});
    end
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      hold  = (cnt == hold_at) && (held < hold_len);
      start = (cnt == restart_at);
      #1;
      if (valid) vseen++;
      if (next_round) nrseen++;
      checks++;
      if (hold) begin
        if ({valid, last, busy, index_x, index_y} !== {3'b001, 2'(cnt % 4), 2'(cnt / 4)}) begin
          failures++;
          $display("FAIL %s_hold c%0d: got %b expected %b", tag, cnt,
                   {valid, last, busy, index_x, index_y}, {3'b001, 2'(cnt % 4), 2'(cnt / 4)});
        end
        held++;
      end else if (cnt < 12) begin
        if ({valid, last, next_round, busy, index_x, index_y} !==
            {1'b1, (cnt == 11), 2'b01, 2'(cnt % 4), 2'(cnt / 4)}) begin
          failures++;
          $display("FAIL %s_cell c%0d: got %b expected %b", tag, cnt,
                   {valid, last, next_round, busy, index_x, index_y},
                   {1'b1, (cnt == 11), 2'b01, 2'(cnt % 4), 2'(cnt / 4)});
        end
        cnt++;
      end else begin
        if ({valid, last, next_round, busy} !== 4'b0011) begin
          failures++;
          $display("FAIL %s_done: got %b expected 0011", tag, {valid, last, next_round, busy});
        end
        done = 1'b1;
      end
      tick();
    end
    hold  = 1'b0;
    start = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: got no DONE expected DONE within 40 cycles", tag);
    end
    #1;
    if (valid) vseen++;
    if (next_round) nrseen++;
    checks++;
    if ({valid, next_round, busy, index_x, index_y} !== 7'b0) begin
      failures++;
      $display("FAIL %s_after: got %b expected 0", tag, {valid, next_round, busy, index_x, index_y});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_stays_idle: got busy=%b expected 0", tag, busy);
    end
    checks++;
    if (vseen !== 12 || nrseen !== 1) begin
      failures++;
      $display("FAIL %s_counts: got valids=%0d rounds=%0d expected 12 and 1", tag, vseen, nrseen);
    end
  endtask

  task automatic test_basic;
    run_scan("basic", -1, 0, -1);
  endtask

  task automatic test_hold;
    run_scan("hold", 6, 3, -1);
  endtask

  task automatic test_restart_ignored;
    run_scan("restart", -1, 0, 1);
  endtask

  task automatic test_reset_mid;
    bit bad;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    // Reset low only between edges must not disturb the scan
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if ({valid, busy, index_x, index_y} !== 6'b11_11_01) begin
      failures++;
      $display("FAIL mid_position: got %b expected 111101", {valid, busy, index_x, index_y});
    end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    checks++;
    if ({valid, last, next_round, busy, index_x, index_y} !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset: got %b expected 0", {valid, last, next_round, busy, index_x, index_y});
    end
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (next_round || busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL mid_no_round: got next_round/busy activity expected none");
    end
  endtask

  task automatic test_small_grids;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    #1;
    checks++;
    if ({v11, l11, n11, b11, x11, y11} !== 6'b110100) begin
      failures++;
      $display("FAIL g11_cell: got %b expected 110100", {v11, l11, n11, b11, x11, y11});
    end
    checks++;
    if ({v12, l12, n12, b12, x12, y12} !== 6'b100100) begin
      failures++;
      $display("FAIL g12_cell0: got %b expected 100100", {v12, l12, n12, b12, x12, y12});
    end
    tick();
    checks++;
    if ({v11, n11, b11} !== 3'b011) begin
      failures++;
      $display("FAIL g11_done: got %b expected 011", {v11, n11, b11});
    end
    checks++;
    if ({v12, l12, n12, b12, x12, y12} !== 6'b110101) begin
      failures++;
      $display("FAIL g12_cell1: got %b expected 110101", {v12, l12, n12, b12, x12, y12});
    end
    tick();
    checks++;
    if ({n11, b11, n12, b12} !== 4'b0011) begin
      failures++;
      $display("FAIL small_end: got %b expected 0011", {n11, b11, n12, b12});
    end
    tick();
    checks++;
    if ({n12, b12} !== 2'b00) begin
      failures++;
      $display("FAIL g12_idle: got %b expected 00", {n12, b12});
    end
  endtask

  task automatic test_continuous;
    int t;
    Reset_c = 1'b1;
    t = 0;
    while (!next_round_c && t < 40) begin
      tick();
      t++;
    end
    checks++;
    if (!next_round_c) begin
      failures++;
      $display("FAIL cont_first_round: got no next_round expected one within 40 cycles");
    end
    tick();
    checks++;
    if ({valid_c, busy_c, index_x_c, index_y_c} !== 6'b110000) begin
      failures++;
      $display("FAIL cont_restart: got %b expected 110000", {valid_c, busy_c, index_x_c, index_y_c});
    end
    t = 1;
    while (!next_round_c && t < 40) begin
      tick();
      t++;
    end
    checks++;
    if (t !== 13) begin
      failures++;
      $display("FAIL cont_period: got %0d expected 13", t);
    end
  endtask

`ifdef GRID_SCAN_ABORT_EN
  task automatic test_abort;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if ({valid, index_x, index_y} !== 5'b1_01_10) begin
      failures++;
      $display("FAIL abort_position: got %b expected 10110", {valid, index_x, index_y});
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if ({valid, last, next_round, busy, index_x, index_y} !== 8'h00) begin
      failures++;
      $display("FAIL abort_idle: got %b expected 0", {valid, last, next_round, busy, index_x, index_y});
    end
    tick();
    checks++;
    if ({next_round, busy} !== 2'b00) begin
      failures++;
      $display("FAIL abort_no_round: got %b expected 00", {next_round, busy});
    end
    run_scan("abort_rescan", -1, 0, -1);
  endtask
`endif

  initial begin
    Reset   = 1'b0;
    Reset_c = 1'b0;
    start   = 1'b0;
    hold    = 1'b0;
    s_start = 1'b0;
`ifdef GRID_SCAN_ABORT_EN
    abort   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_hold();
    test_restart_ignored();
    test_reset_mid();
    test_small_grids();
    test_continuous();
`ifdef GRID_SCAN_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
